// File: rtl/tx_frame_sequencer.sv
// Frame sequencer: pops {last_addr, size} descriptors and streams each frame
// byte-by-byte from the packet buffer over a valid/ready interface, with an inter-frame gap.
module tx_frame_sequencer #(
  parameter int IFG_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       desc_empty,
  input  logic [7:0] desc_last_addr,
  input  logic [7:0] desc_data_size,
  output logic       desc_read_en,
  output logic [7:0] buf_rd_addr,
  input  logic [7:0] buf_rd_data,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  output logic       tx_last,
  input  logic       tx_ready,
  output logic       busy,
  output logic       frame_done,
  output logic       zero_len_drop
);

  localparam int GW         = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  localparam int GAP_LAST_I = (IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0;
  localparam logic [GW-1:0] GAP_LAST = GAP_LAST_I[GW-1:0];

  typedef enum logic [2:0] {
    IDLE,
    POP,
    FETCH,
    LOAD,
    SEND,
    GAP
  } state_t;

  // With no gap configured a finished frame returns straight to IDLE.
  localparam state_t AFTER_FRAME = (IFG_CYCLES > 0) ? GAP : IDLE;

  state_t          state_reg, state_next;
  logic [7:0]      rem_reg;
  logic [7:0]      addr_reg;
  logic [7:0]      data_reg;
  logic            last_reg;
  logic            zero_drop_reg;
  logic [GW-1:0]   gap_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      rem_reg       <= 8'd0;
      addr_reg      <= 8'd0;
      data_reg      <= 8'd0;
      last_reg      <= 1'b0;
      zero_drop_reg <= 1'b0;
      gap_reg       <= '0;
    end else begin
      state_reg     <= state_next;
      zero_drop_reg <= 1'b0;
      gap_reg       <= '0;
      case (state_reg)
        POP: begin
          rem_reg       <= desc_data_size;
          // First byte address; mod-256 so frames may straddle 0xFF/0x00.
          addr_reg      <= desc_last_addr - desc_data_size + 8'd1;
          zero_drop_reg <= (desc_data_size == 8'd0);
        end
        LOAD: begin
          data_reg <= buf_rd_data;
          last_reg <= (rem_reg == 8'd1);
        end
        SEND: begin
          if (tx_ready && !last_reg) begin
            rem_reg  <= rem_reg - 8'd1;
            addr_reg <= addr_reg + 8'd1;
          end
        end
        GAP: begin
          gap_reg <= gap_reg + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (enable && !desc_empty) state_next = POP;
      POP:   state_next = (desc_data_size == 8'd0) ? AFTER_FRAME : FETCH;
      FETCH: state_next = LOAD;
      LOAD:  state_next = SEND;
      SEND: begin
        if (tx_ready) state_next = last_reg ? AFTER_FRAME : FETCH;
      end
      GAP:   if (gap_reg == GAP_LAST) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign desc_read_en  = (state_reg == POP);
  assign buf_rd_addr   = addr_reg;
  assign tx_data       = data_reg;
  assign tx_valid      = (state_reg == SEND);
  assign tx_last       = tx_valid && last_reg;
  assign busy          = (state_reg != IDLE);
  assign frame_done    = tx_valid && tx_ready && last_reg;
  assign zero_len_drop = zero_drop_reg;

endmodule
